// File: rtl/wide_compare_seq.sv
// Multi-cycle wide magnitude comparator: walks operand bytes MSB to LSB through a single
// 8-bit comparator, stopping at the first unequal byte, with a start/busy/done handshake.
module wide_compare_seq #(
    parameter int unsigned BYTES = 4,
    localparam int unsigned CntW = $clog2(BYTES + 1),
    localparam int unsigned IdxW = $clog2(BYTES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [8*BYTES-1:0]   op_a,
    input  logic [8*BYTES-1:0]   op_b,
    output logic                 busy,
    output logic                 done,
    output logic                 eq,
    output logic                 gt,
    output logic                 lt,
    output logic [CntW-1:0]      bytes_used
);

    typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

    state_e              state_q, state_d;
    logic [8*BYTES-1:0]  a_q, a_d, b_q, b_d;
    logic                signed_q, signed_d;
    logic [IdxW-1:0]     index_q, index_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [CntW-1:0]     used_q, used_d;

    // Shared 8-bit comparator datapath (a, b -> eq_out, gt_out)
    logic [7:0] cmp_a, cmp_b;
    logic       eq_out, gt_out;

    always_comb begin
        cmp_a = a_q[8*index_q +: 8];
        cmp_b = b_q[8*index_q +: 8];
        // Flipping both sign bits maps two's-complement order onto unsigned order.
        if (signed_q && (index_q == IdxW'(BYTES - 1))) begin
            cmp_a[7] = ~cmp_a[7];
            cmp_b[7] = ~cmp_b[7];
        end
        eq_out = (cmp_a == cmp_b);
        gt_out = (cmp_a > cmp_b);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        index_d  = index_q;
        count_d  = count_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        used_d   = used_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    signed_d = signed_mode;
                    index_d  = IdxW'(BYTES - 1);
                    count_d  = '0;
                    eq_d     = 1'b0;
                    gt_d     = 1'b0;
                    lt_d     = 1'b0;
                    used_d   = '0;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                if (!eq_out) begin
                    eq_d    = 1'b0;
                    gt_d    = gt_out;
                    lt_d    = ~gt_out;
                    used_d  = count_q + CntW'(1);
                    state_d = StDone;
                end else if (index_q != '0) begin
                    index_d = index_q - IdxW'(1);
                    count_d = count_q + CntW'(1);
                end else begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    used_d  = CntW'(BYTES);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            index_q  <= IdxW'(BYTES - 1);
            count_q  <= '0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            used_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            index_q  <= index_d;
            count_q  <= count_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            used_q   <= used_d;
        end
    end

    assign busy       = (state_q == StCmp);
    assign done       = (state_q == StDone);
    assign eq         = eq_q;
    assign gt         = gt_q;
    assign lt         = lt_q;
    assign bytes_used = used_q;

endmodule
